// File: rtl/id_pkg.sv
// Shared opcodes, one-hot format bit positions and the decoded-field record
// held in the decode stage's output and skid registers.
package id_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_REG32  = 7'b0111011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam int T_R = 5;
  localparam int T_I = 4;
  localparam int T_S = 3;
  localparam int T_B = 2;
  localparam int T_U = 1;
  localparam int T_J = 0;

  // Width-independent fields; the XLEN-wide immediate and the PC live beside
  // this record inside the stage.
  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [5:0] typ;
    logic       illegal;
  } dec_t;

endpackage

// File: rtl/id_imm_gen.sv
// Combinational format classifier and sign-extended immediate generator.
// Unrecognised encodings give type 0, immediate 0 and the illegal flag.
module id_imm_gen
  import id_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     i_ins,
  output logic [5:0]      o_type,
  output logic [XLEN-1:0] o_imm,
  output logic            o_illegal
);

  logic [5:0]  w_type;
  logic [31:0] w_raw;

  always_comb begin
    w_type = '0;
    if (i_ins[1:0] == 2'b11) begin
      case (i_ins[6:0])
        OP_REG:                                    w_type[T_R] = 1'b1;
        OP_REG32:                                  w_type[T_R] = (XLEN == 64);
        OP_IMM, OP_LOAD, OP_JALR, OP_FENCE, OP_SYSTEM: w_type[T_I] = 1'b1;
        OP_IMM32:                                  w_type[T_I] = (XLEN == 64);
        OP_STORE:                                  w_type[T_S] = 1'b1;
        OP_BRANCH:                                 w_type[T_B] = 1'b1;
        OP_LUI, OP_AUIPC:                          w_type[T_U] = 1'b1;
        OP_JAL:                                    w_type[T_J] = 1'b1;
        default:                                   w_type = '0;
      endcase
    end
  end

  // Build a 32-bit signed value first, then widen once to XLEN.
  always_comb begin
    w_raw = '0;
    if (w_type[T_I])
      w_raw = {{20{i_ins[31]}}, i_ins[31:20]};
    else if (w_type[T_S])
      w_raw = {{20{i_ins[31]}}, i_ins[31:25], i_ins[11:7]};
    else if (w_type[T_B])
      w_raw = {{19{i_ins[31]}}, i_ins[31], i_ins[7], i_ins[30:25], i_ins[11:8], 1'b0};
    else if (w_type[T_U])
      w_raw = {i_ins[31:12], 12'b0};
    else if (w_type[T_J])
      w_raw = {{11{i_ins[31]}}, i_ins[31], i_ins[19:12], i_ins[20], i_ins[30:21], 1'b0};
  end

  assign o_type    = w_type;
  assign o_imm     = XLEN'($signed(w_raw));
  assign o_illegal = (w_type == 6'b0);

endmodule

// File: rtl/id_stage_pipe.sv
// Registered decode stage: one cycle latency, one instruction per cycle; a skid
// register absorbs one extra instruction so in_ready comes only from flops.
module id_stage_pipe
  import id_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int PC_W = XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_ins,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [6:0]      out_opcode,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic [XLEN-1:0] out_imm,
  output logic [5:0]      out_type,
  output logic            out_illegal
);

  typedef struct packed {
    dec_t            dec;
    logic [XLEN-1:0] imm;
    logic [PC_W-1:0] pc;
  } slot_t;

  logic [5:0]      w_type;
  logic [XLEN-1:0] w_imm;
  logic            w_illegal;
  slot_t           w_in;
  logic            w_acc;

  slot_t r_o;
  slot_t r_k;
  logic  r_o_vld;
  logic  r_k_vld;

  id_imm_gen #(.XLEN(XLEN)) u_imm (
    .i_ins     (in_ins),
    .o_type    (w_type),
    .o_imm     (w_imm),
    .o_illegal (w_illegal)
  );

  always_comb begin
    w_in             = '0;
    w_in.dec.rs1     = in_ins[19:15];
    w_in.dec.rs2     = in_ins[24:20];
    w_in.dec.rd      = in_ins[11:7];
    w_in.dec.opcode  = in_ins[6:0];
    w_in.dec.funct3  = in_ins[14:12];
    w_in.dec.funct7  = in_ins[31:25];
    w_in.dec.typ     = w_type;
    w_in.dec.illegal = w_illegal;
    w_in.imm         = w_imm;
    w_in.pc          = in_pc;
  end

  // The skid slot is the only thing that can refuse input; rst overrides it.
  assign in_ready = ~r_k_vld & ~rst;
  assign w_acc    = in_valid & in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_o     <= '0;
      r_k     <= '0;
      r_o_vld <= 1'b0;
      r_k_vld <= 1'b0;
    end else if (flush) begin
      r_o_vld <= 1'b0;
      r_k_vld <= 1'b0;
    end else if (!r_o_vld || out_ready) begin
      if (r_k_vld) begin
        r_o     <= r_k;
        r_o_vld <= 1'b1;
        r_k_vld <= 1'b0;
      end else begin
        r_o_vld <= w_acc;
        if (w_acc) r_o <= w_in;
      end
    end else if (w_acc) begin
      r_k     <= w_in;
      r_k_vld <= 1'b1;
    end
  end

  assign out_valid   = r_o_vld;
  assign out_pc      = r_o.pc;
  assign out_rs1     = r_o.dec.rs1;
  assign out_rs2     = r_o.dec.rs2;
  assign out_rd      = r_o.dec.rd;
  assign out_opcode  = r_o.dec.opcode;
  assign out_funct3  = r_o.dec.funct3;
  assign out_funct7  = r_o.dec.funct7;
  assign out_imm     = r_o.imm;
  assign out_type    = r_o.dec.typ;
  assign out_illegal = r_o.dec.illegal;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Drives an RV32 and an RV64 decode stage with identical traffic and checks
// both against a two-deep FIFO reference with an arithmetic immediate model.
module tb_id_stage_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_ins = '0;
  logic [63:0] in_pc = '0;
  logic        out_ready = 1'b0;

  logic        rdy_a, ov_a, ill_a;
  logic [31:0] pc_a, imm_a;
  logic [4:0]  rs1_a, rs2_a, rd_a;
  logic [6:0]  opc_a, f7_a;
  logic [2:0]  f3_a;
  logic [5:0]  typ_a;

  logic        rdy_b, ov_b, ill_b;
  logic [63:0] pc_b, imm_b;
  logic [4:0]  rs1_b, rs2_b, rd_b;
  logic [6:0]  opc_b, f7_b;
  logic [2:0]  f3_b;
  logic [5:0]  typ_b;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] ins;
    logic [63:0] pc;
  } item_t;
  item_t q[$];
  bit    last_acc = 0;

  always #5 clk = ~clk;

  id_stage_pipe #(.XLEN(32), .PC_W(32)) u_a (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy_a), .in_ins(in_ins), .in_pc(in_pc[31:0]),
    .out_valid(ov_a), .out_ready(out_ready), .out_pc(pc_a),
    .out_rs1(rs1_a), .out_rs2(rs2_a), .out_rd(rd_a), .out_opcode(opc_a),
    .out_funct3(f3_a), .out_funct7(f7_a), .out_imm(imm_a), .out_type(typ_a),
    .out_illegal(ill_a)
  );

  id_stage_pipe #(.XLEN(64), .PC_W(64)) u_b (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(rdy_b), .in_ins(in_ins), .in_pc(in_pc),
    .out_valid(ov_b), .out_ready(out_ready), .out_pc(pc_b),
    .out_rs1(rs1_b), .out_rs2(rs2_b), .out_rd(rd_b), .out_opcode(opc_b),
    .out_funct3(f3_b), .out_funct7(f7_b), .out_imm(imm_b), .out_type(typ_b),
    .out_illegal(ill_b)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Format and immediate worked out as plain signed integers.
  function automatic void ref_dec(input logic [31:0] ins, input bit x64,
                                  output logic [5:0] typ, output logic [63:0] imm,
                                  output bit ill);
    longint v;
    typ = 6'b0;
    if (ins[1:0] == 2'b11) begin
      case (ins[6:0])
        7'h33:                             typ = 6'b100000;
        7'h3B:                             typ = x64 ? 6'b100000 : 6'b0;
        7'h13, 7'h03, 7'h67, 7'h0F, 7'h73: typ = 6'b010000;
        7'h1B:                             typ = x64 ? 6'b010000 : 6'b0;
        7'h23:                             typ = 6'b001000;
        7'h63:                             typ = 6'b000100;
        7'h37, 7'h17:                      typ = 6'b000010;
        7'h6F:                             typ = 6'b000001;
        default:                           typ = 6'b0;
      endcase
    end
    v = 0;
    case (typ)
      6'b010000: begin v = ins[31:20]; if (v >= 2048) v -= 4096; end
      6'b001000: begin v = {ins[31:25], ins[11:7]}; if (v >= 2048) v -= 4096; end
      6'b000100: begin
        v = {ins[31], ins[7], ins[30:25], ins[11:8]};
        v = v * 2;
        if (v >= 4096) v -= 8192;
      end
      6'b000010: begin
        v = ins[31:12];
        v = v * 4096;
        if (ins[31]) v -= (longint'(1) << 32);
      end
      6'b000001: begin
        v = {ins[31], ins[19:12], ins[20], ins[30:21]};
        v = v * 2;
        if (v >= (longint'(1) << 20)) v -= (longint'(1) << 21);
      end
      default: v = 0;
    endcase
    imm = x64 ? 64'(v) : (64'(v) & 64'hFFFF_FFFF);
    ill = (typ == 6'b0);
  endfunction

  task automatic check_out(input item_t it);
    logic [5:0]  t32, t64;
    logic [63:0] i32, i64;
    bit          l32, l64;
    ref_dec(it.ins, 1'b0, t32, i32, l32);
    ref_dec(it.ins, 1'b1, t64, i64, l64);
    chk("pc32", pc_a, {32'b0, it.pc[31:0]});
    chk("pc64", pc_b, it.pc);
    chk("rs1_32", rs1_a, it.ins[19:15]);
    chk("rs2_32", rs2_a, it.ins[24:20]);
    chk("rd_32", rd_a, it.ins[11:7]);
    chk("opc_32", opc_a, it.ins[6:0]);
    chk("f3_32", f3_a, it.ins[14:12]);
    chk("f7_32", f7_a, it.ins[31:25]);
    chk("rd_64", rd_b, it.ins[11:7]);
    chk("rs1_64", rs1_b, it.ins[19:15]);
    chk("f7_64", f7_b, it.ins[31:25]);
    chk("type32", typ_a, t32);
    chk("imm32", imm_a, i32);
    chk("ill32", ill_a, l32);
    chk("type64", typ_b, t64);
    chk("imm64", imm_b, i64);
    chk("ill64", ill_b, l64);
  endtask

  // Observe at the falling edge, advance the reference, return 1 after the rise.
  task automatic tick();
    bit exp_rdy, acc, drain;
    @(negedge clk);
    exp_rdy = !rst && (q.size() < 2);
    chk("in_ready32", rdy_a, exp_rdy);
    chk("in_ready64", rdy_b, exp_rdy);
    chk("out_valid32", ov_a, q.size() > 0);
    chk("out_valid64", ov_b, q.size() > 0);
    if (q.size() > 0) check_out(q[0]);
    acc   = in_valid && exp_rdy && !flush;
    drain = (q.size() > 0) && out_ready;
    if (rst || flush) q.delete();
    else begin
      if (drain) void'(q.pop_front());
      if (acc) q.push_back('{ins: in_ins, pc: in_pc});
    end
    last_acc = acc;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] ins, input logic [63:0] pc);
    int n;
    in_valid = 1'b1; in_ins = ins; in_pc = pc;
    n = 0;
    do begin tick(); n++; end while (!last_acc && n < 20);
    if (!last_acc) chk("send_timeout", 64'd0, 64'd1);
    in_valid = 1'b0;
  endtask

  logic [6:0] ops [15] = '{7'h33, 7'h3B, 7'h13, 7'h03, 7'h67, 7'h0F, 7'h73, 7'h1B,
                           7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h7F, 7'h0B};

  initial begin
    #200000;
    $display("FAIL global_timeout observed=hang expected=finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] r;
    // Reset state
    tick(); tick();
    chk("rst_in_ready", rdy_a, 64'd0);
    chk("rst_out_valid", ov_a, 64'd0);
    chk("rst_imm64", imm_b, 64'd0);
    chk("rst_pc32", pc_a, 64'd0);
    chk("rst_type", typ_a, 64'd0);
    chk("rst_ill", ill_b, 64'd0);
    rst = 1'b0;
    tick();

    // Directed decodes
    out_ready = 1'b1;
    send(32'hFFF10093, 64'h100);
    chk("addi_vld", ov_a, 64'd1);
    chk("addi_rd", rd_a, 64'd1);
    chk("addi_rs1", rs1_a, 64'd2);
    chk("addi_type", typ_a, 64'b010000);
    chk("addi_imm", imm_a, 64'hFFFF_FFFF);
    chk("addi_ill", ill_a, 64'd0);
    send(32'hFE208EE3, 64'h104);
    chk("beq_rs1", rs1_a, 64'd1);
    chk("beq_rs2", rs2_a, 64'd2);
    chk("beq_type", typ_a, 64'b000100);
    chk("beq_imm", imm_a, 64'hFFFF_FFFC);
    send(32'h123452B7, 64'h108);
    chk("lui_rd", rd_a, 64'd5);
    chk("lui_type", typ_a, 64'b000010);
    chk("lui_imm", imm_a, 64'h1234_5000);
    send(32'h800002B7, 64'h10C);
    chk("lui64_imm", imm_b, 64'hFFFF_FFFF_8000_0000);
    chk("lui32_imm", imm_a, 64'h8000_0000);
    send(32'h0000003B, 64'h110);
    chk("addw64_type", typ_b, 64'b100000);
    chk("addw64_ill", ill_b, 64'd0);
    chk("addw32_ill", ill_a, 64'd1);
    chk("addw32_type", typ_a, 64'd0);
    send(32'h00000000, 64'h114);
    chk("zero_ill", ill_a, 64'd1);
    chk("zero_type", typ_b, 64'd0);
    chk("zero_imm", imm_b, 64'd0);
    tick();

    // Backpressure: A in O, B in K, C held off
    out_ready = 1'b0;
    in_valid = 1'b1; in_ins = 32'h00100093; in_pc = 64'hA0; tick();
    in_ins = 32'h00200113; in_pc = 64'hB0; tick();
    in_ins = 32'h00300193; in_pc = 64'hC0;
    chk("bp_in_ready", rdy_a, 64'd0);
    chk("bp_head", pc_a, 64'hA0);
    tick(); tick();
    chk("bp_still_head", pc_a, 64'hA0);
    out_ready = 1'b1;
    tick();
    chk("bp_second", pc_a, 64'hB0);
    tick();
    chk("bp_third", pc_a, 64'hC0);
    in_valid = 1'b0;
    tick(); tick();

    // Flush with both slots full and an offered instruction
    out_ready = 1'b0;
    in_valid = 1'b1; in_ins = 32'h00100093; in_pc = 64'h200; tick();
    in_ins = 32'h00200113; in_pc = 64'h204; tick();
    in_ins = 32'h00400213; in_pc = 64'h208; flush = 1'b1; tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_out_valid", ov_a, 64'd0);
    chk("flush_in_ready", rdy_b, 64'd1);
    out_ready = 1'b1;
    send(32'hFFF10093, 64'h20C);
    chk("post_flush_pc", pc_a, 64'h20C);
    chk("post_flush_imm", imm_b, 64'hFFFF_FFFF_FFFF_FFFF);
    tick();

    // Randomised traffic, in_valid held until accepted
    last_acc = 1'b1;
    for (int i = 0; i < 500; i++) begin
      if (!in_valid || last_acc) begin
        r = $urandom();
        if ($urandom_range(0, 7) != 0) r[6:0] = ops[$urandom_range(0, 14)];
        in_ins = r;
        in_pc = {$urandom(), $urandom()};
        in_valid = ($urandom_range(0, 3) != 0);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 39) == 0);
      tick();
    end
    flush = 1'b0;

    // Reset while an instruction is held
    out_ready = 1'b0;
    send(32'h00500293, 64'h300);
    chk("mid_vld_before", ov_a, 64'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_vld32", ov_a, 64'd0);
    chk("mid_rst_vld64", ov_b, 64'd0);
    chk("mid_rst_rdy", rdy_a, 64'd0);
    q.delete();
    in_valid = 1'b1; in_ins = 32'h00600313;
    tick(); tick();
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("post_rst_rdy", rdy_a, 64'd1);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/id_stage_pipe.md
Name: id_stage_pipe

Overview:
Registered instruction-decode stage for the RV32I/RV64I core.
- Splits a 32-bit instruction into register, opcode and function fields.
- Classifies the instruction format as one-hot R/I/S/B/U/J.
- Produces the fully sign-extended, XLEN-wide immediate and flags illegal encodings.
- Sits between fetch and execute. Has a valid/ready handshake on both sides, a 2-entry skid buffer for full-throughput backpressure, and a pipeline flush input.

Parameters:
XLEN, 32, datapath and immediate width; legal values are 32 and 64.
PC_W, XLEN, width of the PC carried alongside the instruction.

Ports:
clk  in  1  clock, all state rising-edge
rst  in  1  reset, asynchronous, active-high
flush  in  1  discard all held and incoming instructions
in_valid  in  1  fetch presents an instruction
in_ready  out  1  stage can accept this cycle
in_ins  in  32  instruction word
in_pc  in  PC_W  PC of in_ins
out_valid  out  1  decoded instruction available
out_ready  in  1  execute accepts this cycle
out_pc  out  PC_W  PC of the decoded instruction
out_rs1  out  5  ins[19:15]
out_rs2  out  5  ins[24:20]
out_rd  out  5  ins[11:7]
out_opcode  out  7  ins[6:0]
out_funct3  out  3  ins[14:12]
out_funct7  out  7  ins[31:25], full field
out_imm  out  XLEN  sign-extended immediate
out_type  out  6  one-hot {R,I,S,B,U,J}, bit5=R, bit0=J
out_illegal  out  1  unrecognised encoding

Behaviour:
- Reset (async assert, clk-synchronous deassert is the system's job):
  - out_valid=0, skid_valid=0, every out_* data register=0.
  - in_ready is forced to 0 while rst=1.
- Handshake:
  - Input transfer when in_valid&in_ready. Output transfer when out_valid&out_ready.
  - in_valid/in_ins/in_pc must be held stable until transfer. out_* stay stable while out_valid&~out_ready.
- Latency and throughput: an accepted instruction appears on out_* the next cycle when the output register is free. Sustains 1 instruction/cycle with out_ready=1.
- Storage: output register (O) plus skid register (K). in_ready = ~skid_valid, registered, not combinational from out_ready.
- Update rules:
  - O empty or being drained, K empty: input goes to O.
  - O full and stalled: input goes to K; in_ready falls next cycle.
  - O drains while K full: K moves to O, K empties, in_ready rises next cycle.
  - Strict FIFO order always.
- Decode happens before the register; O and K hold already-decoded fields.
- flush=1:
  - Next cycle out_valid=0, skid_valid=0, in_ready=1.
  - An input offered in the flush cycle is dropped, not accepted.
  - Flush has priority over all transfers. Data registers need not clear.
- Format classification (ins[1:0] must be 2'b11):
  - R: 0110011; plus 0111011 when XLEN=64.
  - I: 0010011, 0000011, 1100111, 0001111, 1110011; plus 0011011 when XLEN=64.
  - S: 0100011.
  - B: 1100011.
  - U: 0110111, 0010111.
  - J: 1101111.
- Immediates, sign-extended from the top bit to XLEN:
  - I = ins[31:20].
  - S = {ins[31:25],ins[11:7]}.
  - B = {ins[31],ins[7],ins[30:25],ins[11:8],0}.
  - U = {ins[31:12],12'b0}; sign-extended when XLEN=64.
  - J = {ins[31],ins[19:12],ins[20],ins[30:21],0}.
  - R: 0.
- Illegal: any other opcode or ins[1:0]!=2'b11 gives out_type=0, out_imm=0, out_illegal=1. The instruction still flows through the handshake normally; the field outputs still carry raw slices.
- Reset asserted mid-stream: all held instructions are lost immediately; out_valid falls asynchronously.

Decomposition:
- Package id_pkg:
  - Opcode localparams: OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_IMM, OP_REG, OP_IMM32, OP_REG32, OP_FENCE, OP_SYSTEM.
  - Type-bit indices T_R..T_J.
  - Packed struct dec_t grouping all decoded fields, used for O and K.
- Sub-module id_imm_gen: combinational; ins plus XLEN parameter in; type one-hot, imm and illegal out.
- id_stage_pipe holds the handshake, skid logic and flush.

Test Plan:
1. XLEN=32, in_ins=0xFFF10093 (addi x1,x2,-1), out_ready=1 -> next cycle out_valid=1, rd=1, rs1=2, type=I (6'b010000), imm=0xFFFFFFFF, illegal=0.
2. in_ins=0xFE208EE3 (beq x1,x2,-4) -> rs1=1, rs2=2, type=B, imm=0xFFFFFFFC. in_ins=0x123452B7 (lui x5,0x12345) -> rd=5, type=U, imm=0x12345000.
3. XLEN=64, in_ins=0x800002B7 (lui x5,0x80000) -> imm=0xFFFFFFFF80000000. in_ins=0x0000003B (addw) -> type=R, illegal=0. With XLEN=32 the same word gives illegal=1.
4. Backpressure: out_ready=0, push A,B,C back-to-back -> A in O, B in K, in_ready=0 from cycle 3, C held. Raise out_ready -> A,B,C emerge on consecutive cycles in order with no loss or duplication.
5. Flush with O and K full and in_valid=1 -> next cycle out_valid=0, in_ready=1, the offered instruction is not accepted; a following instruction is decoded normally.
6. in_ins=0x00000000 -> illegal=1, type=0, imm=0. Assert rst mid-stream with out_valid=1 -> out_valid=0 immediately, in_ready=0 until rst deasserts.
